// File: rtl/prbs_mon_pkg.sv
// Shared types, width helpers and saturation constants for prbs_err_monitor.
// Optional window snapshot outputs are enabled by PRBS_MON_WIN_SNAPSHOT_EN.
package prbs_mon_pkg;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } mon_state_t;

   localparam logic [15:0] SYNC_LOSS_MAX = 16'hFFFF;

   function automatic int at_least_one(input int w);
      return (w < 1) ? 1 : w;
   endfunction

   // Width of a count of set bits in an nbits-wide vector
   function automatic int pop_w(input int nbits);
      return $clog2(nbits + 1);
   endfunction

   // Clean-run counter only needs to reach lock_cnt-1
   function automatic int clean_w(input int lock_cnt);
      return at_least_one($clog2(lock_cnt));
   endfunction

   // Window position counter runs 0 .. win_len-1
   function automatic int win_words_w(input int win_len);
      return at_least_one($clog2(win_len));
   endfunction

   // Errored-word count in a window never exceeds thr-1 before sync is lost
   function automatic int win_bad_w(input int thr);
      return at_least_one($clog2(thr));
   endfunction

   // Total bit errors that can occur inside one window
   function automatic int win_err_w(input int win_len, input int nbits);
      return $clog2(win_len * nbits + 1);
   endfunction

endpackage

// File: rtl/prbs_popcount.sv
// Combinational population count of an NBITS-wide error vector.
module prbs_popcount
   import prbs_mon_pkg::*;
#(
   parameter int NBITS = 16
) (
   input  logic [NBITS-1:0]        vec,
   output logic [pop_w(NBITS)-1:0] count
);

   localparam int CW = pop_w(NBITS);

   // Sum every bit; synthesis rebalances the chain into an adder tree
   always_comb begin
      logic [CW-1:0] acc;
      acc = '0;
      for (int unsigned i = 0; i < NBITS; i++) begin
         acc = acc + CW'(vec[i]);
      end
      count = acc;
   end

endmodule

// File: rtl/prbs_err_monitor.sv
// PRBS error monitor: lock / loss-of-sync tracking and saturating BER
// statistics over the checker's per-bit error vector.
// Optional macro PRBS_MON_WIN_SNAPSHOT_EN adds WIN_ERR / WIN_DONE outputs.
module prbs_err_monitor
   import prbs_mon_pkg::*;
#(
   parameter int NBITS      = 16,
   parameter int LOCK_CNT   = 64,
   parameter int WIN_LEN    = 1024,
   parameter int UNLOCK_THR = 16,
   parameter int CNT_W      = 48
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NBITS-1:0]     ERR_IN,
   input  logic                 ERR_VALID,
   input  logic                 CLR,
   output logic                 LOCKED,
   output logic                 LOS_PULSE,
   output logic [CNT_W-1:0]     ERR_CNT,
   output logic [CNT_W-1:0]     WORD_CNT,
   output logic [15:0]          SYNC_LOSS_CNT
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
   ,
   output logic [win_err_w(WIN_LEN, NBITS)-1:0] WIN_ERR,
   output logic                                 WIN_DONE
`endif
);

   localparam int PW  = pop_w(NBITS);
   localparam int CLW = clean_w(LOCK_CNT);
   localparam int WWW = win_words_w(WIN_LEN);
   localparam int WBW = win_bad_w(UNLOCK_THR);

   // Stage 1: registered error word and its qualifier
   logic [NBITS-1:0] err_q;
   logic             vld_q;
   logic [PW-1:0]    pop;
   logic             bad;

   // Stage 2: FSM and window state
   mon_state_t       state_q, state_d;
   logic [CLW-1:0]   clean_q, clean_d;
   logic [WWW-1:0]   win_words_q, win_words_d;
   logic [WBW-1:0]   win_bad_q, win_bad_d;
   logic [CNT_W-1:0] err_cnt_d, word_cnt_d;
   logic [15:0]      sync_loss_d;
   logic             los_d;

   logic [CNT_W:0]   err_sum;
   logic [CNT_W-1:0] err_sat, word_sat;
   logic [15:0]      loss_sat;
   logic             thr_hit, lock_hit, win_end;

`ifdef PRBS_MON_WIN_SNAPSHOT_EN
   localparam int WEW = win_err_w(WIN_LEN, NBITS);
   logic [WEW-1:0] win_acc_q, win_acc_d, win_err_d;
   logic           win_done_d;
`endif

   // Capture the incoming word; reset discards anything in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= '0;
         vld_q <= 1'b0;
      end else begin
         err_q <= ERR_IN;
         vld_q <= ERR_VALID;
      end
   end

   prbs_popcount #(
      .NBITS (NBITS)
   ) u_popcount (
      .vec   (err_q),
      .count (pop)
   );

   assign bad = |err_q;

   // Saturating increments and decision terms for the current word
   always_comb begin
      err_sum  = {1'b0, ERR_CNT} + (CNT_W+1)'(pop);
      err_sat  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
      word_sat = (&WORD_CNT) ? WORD_CNT : WORD_CNT + CNT_W'(1);
      loss_sat = (SYNC_LOSS_CNT == SYNC_LOSS_MAX) ? SYNC_LOSS_CNT
                                                  : SYNC_LOSS_CNT + 16'd1;
      thr_hit  = (32'(win_bad_q) + 32'(bad)) >= 32'(UNLOCK_THR);
      lock_hit = (clean_q == CLW'(LOCK_CNT - 1));
      win_end  = (win_words_q == WWW'(WIN_LEN - 1));
   end

   // Next-state and counter update; CLR overrides the statistics last
   always_comb begin
      state_d     = state_q;
      clean_d     = clean_q;
      win_words_d = win_words_q;
      win_bad_d   = win_bad_q;
      err_cnt_d   = ERR_CNT;
      word_cnt_d  = WORD_CNT;
      sync_loss_d = SYNC_LOSS_CNT;
      los_d       = 1'b0;
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
      win_acc_d   = win_acc_q;
      win_err_d   = WIN_ERR;
      win_done_d  = 1'b0;
`endif
      if (vld_q) begin
         unique case (state_q)
            ST_SEARCH: begin
               if (bad) begin
                  clean_d = '0;
               end else if (lock_hit) begin
                  state_d     = ST_LOCKED;
                  clean_d     = '0;
                  win_words_d = '0;
                  win_bad_d   = '0;
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
                  win_acc_d   = '0;
`endif
               end else begin
                  clean_d = clean_q + CLW'(1);
               end
            end
            ST_LOCKED: begin
               err_cnt_d  = err_sat;
               word_cnt_d = word_sat;
               if (thr_hit) begin
                  // Loss of sync wins over a window completing on the same word
                  state_d     = ST_SEARCH;
                  los_d       = 1'b1;
                  sync_loss_d = loss_sat;
                  clean_d     = '0;
                  win_words_d = '0;
                  win_bad_d   = '0;
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
                  win_acc_d   = '0;
`endif
               end else if (win_end) begin
                  win_words_d = '0;
                  win_bad_d   = '0;
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
                  win_err_d   = win_acc_q + WEW'(pop);
                  win_done_d  = 1'b1;
                  win_acc_d   = '0;
`endif
               end else begin
                  win_words_d = win_words_q + WWW'(1);
                  win_bad_d   = win_bad_q + WBW'(bad);
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
                  win_acc_d   = win_acc_q + WEW'(pop);
`endif
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
      if (CLR) begin
         err_cnt_d   = '0;
         word_cnt_d  = '0;
         sync_loss_d = '0;
      end
   end

   // Stage 2 registers and registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= ST_SEARCH;
         clean_q       <= '0;
         win_words_q   <= '0;
         win_bad_q     <= '0;
         LOCKED        <= 1'b0;
         LOS_PULSE     <= 1'b0;
         ERR_CNT       <= '0;
         WORD_CNT      <= '0;
         SYNC_LOSS_CNT <= '0;
      end else begin
         state_q       <= state_d;
         clean_q       <= clean_d;
         win_words_q   <= win_words_d;
         win_bad_q     <= win_bad_d;
         LOCKED        <= (state_d == ST_LOCKED);
         LOS_PULSE     <= los_d;
         ERR_CNT       <= err_cnt_d;
         WORD_CNT      <= word_cnt_d;
         SYNC_LOSS_CNT <= sync_loss_d;
      end
   end

`ifdef PRBS_MON_WIN_SNAPSHOT_EN
   // Window snapshot registers; untouched by CLR
   always_ff @(posedge CLK) begin
      if (RST) begin
         win_acc_q <= '0;
         WIN_ERR   <= '0;
         WIN_DONE  <= 1'b0;
      end else begin
         win_acc_q <= win_acc_d;
         WIN_ERR   <= win_err_d;
         WIN_DONE  <= win_done_d;
      end
   end
`endif

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Self-checking bench for prbs_err_monitor: word-level reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
// Honours PRBS_MON_WIN_SNAPSHOT_EN for the optional window outputs.
module tb_prbs_err_monitor;

   localparam int NBITS      = 16;
   localparam int LOCK_CNT   = 4;
   localparam int WIN_LEN    = 8;
   localparam int UNLOCK_THR = 3;
   localparam int CNT_W      = 8;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;
   localparam int WEW        = $clog2(WIN_LEN * NBITS + 1);

   logic             CLK = 1'b0;
   logic             RST;
   logic [NBITS-1:0] ERR_IN;
   logic             ERR_VALID;
   logic             CLR;
   logic             LOCKED;
   logic             LOS_PULSE;
   logic [CNT_W-1:0] ERR_CNT;
   logic [CNT_W-1:0] WORD_CNT;
   logic [15:0]      SYNC_LOSS_CNT;
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
   logic [WEW-1:0]   WIN_ERR;
   logic             WIN_DONE;
`endif

   prbs_err_monitor #(
      .NBITS      (NBITS),
      .LOCK_CNT   (LOCK_CNT),
      .WIN_LEN    (WIN_LEN),
      .UNLOCK_THR (UNLOCK_THR),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ERR_IN        (ERR_IN),
      .ERR_VALID     (ERR_VALID),
      .CLR           (CLR),
      .LOCKED        (LOCKED),
      .LOS_PULSE     (LOS_PULSE),
      .ERR_CNT       (ERR_CNT),
      .WORD_CNT      (WORD_CNT),
      .SYNC_LOSS_CNT (SYNC_LOSS_CNT)
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
      ,
      .WIN_ERR       (WIN_ERR),
      .WIN_DONE      (WIN_DONE)
`endif
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model (word level) ----------------
   bit               m_locked, m_los, m_win_done;
   int               m_run, m_wwords, m_wbad, m_winacc, m_win_err;
   int               m_err, m_words, m_loss;
   logic [NBITS-1:0] d_err;
   bit               d_vld;

   task automatic model_reset();
      m_locked = 0; m_los = 0; m_win_done = 0;
      m_run = 0; m_wwords = 0; m_wbad = 0; m_winacc = 0; m_win_err = 0;
      m_err = 0; m_words = 0; m_loss = 0;
      d_err = '0; d_vld = 0;
   endtask

   task automatic model_word(input logic [NBITS-1:0] w);
      int p;
      bit b;
      p = $countones(w);
      b = (w != 0);
      if (!m_locked) begin
         m_run = b ? 0 : m_run + 1;
         if (m_run == LOCK_CNT) begin
            m_locked = 1; m_run = 0;
            m_wwords = 0; m_wbad = 0; m_winacc = 0;
         end
      end else begin
         m_err    = (m_err + p > CNT_MAX) ? CNT_MAX : m_err + p;
         m_words  = (m_words + 1 > CNT_MAX) ? CNT_MAX : m_words + 1;
         m_wwords = m_wwords + 1;
         m_wbad   = m_wbad + int'(b);
         m_winacc = m_winacc + p;
         if (m_wbad >= UNLOCK_THR) begin
            m_locked = 0; m_los = 1; m_run = 0;
            m_loss = (m_loss == 65535) ? 65535 : m_loss + 1;
            m_wwords = 0; m_wbad = 0; m_winacc = 0;
         end else if (m_wwords == WIN_LEN) begin
            m_win_err = m_winacc; m_win_done = 1;
            m_wwords = 0; m_wbad = 0; m_winacc = 0;
         end
      end
   endtask

   // A word presented in one cycle is judged at the following edge
   always @(posedge CLK) begin
      if (RST) begin
         model_reset();
      end else begin
         m_los = 0;
         m_win_done = 0;
         if (d_vld) model_word(d_err);
         if (CLR) begin
            m_err = 0; m_words = 0; m_loss = 0;
         end
         d_err = ERR_IN;
         d_vld = ERR_VALID;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;
   bit check_en = 0;

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [NBITS-1:0] e, input bit v, input bit c);
      @(posedge CLK);
      #2;
      ERR_IN    = e;
      ERR_VALID = v;
      CLR       = c;
   endtask

   task automatic idle(input int n);
      repeat (n) send('0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #2;
      RST = 1; ERR_VALID = 0; CLR = 0;
      @(posedge CLK);
      #2;
      RST = 0;
   endtask

   initial begin
      logic [NBITS-1:0] e;
      bit               v, c;
      int               rate;

      RST = 1; ERR_IN = '0; ERR_VALID = 0; CLR = 0;
      @(posedge CLK);
      check_en = 1;

      fork
         forever begin
            @(negedge CLK);
            if (check_en) begin
               chk("cyc_locked", LOCKED, m_locked);
               chk("cyc_los",    LOS_PULSE, m_los);
               chk("cyc_errcnt", ERR_CNT, m_err);
               chk("cyc_wordcnt", WORD_CNT, m_words);
               chk("cyc_losscnt", SYNC_LOSS_CNT, m_loss);
`ifdef PRBS_MON_WIN_SNAPSHOT_EN
               chk("cyc_windone", WIN_DONE, m_win_done);
               chk("cyc_winerr",  WIN_ERR, m_win_err);
`endif
            end
         end
      join_none

      @(posedge CLK);
      #2;
      RST = 0;
      @(negedge CLK);
      chk("rst_locked", LOCKED, 0);
      chk("rst_los", LOS_PULSE, 0);
      chk("rst_errcnt", ERR_CNT, 0);
      chk("rst_wordcnt", WORD_CNT, 0);
      chk("rst_losscnt", SYNC_LOSS_CNT, 0);

      // Lock: start-up burst, broken clean run, then four clean words
      repeat (3) send(16'hFFFF, 1, 0);
      send(16'h0000, 1, 0);
      send(16'h0000, 1, 0);
      send(16'h0400, 1, 0);
      repeat (3) send(16'h0000, 1, 0);
      idle(2);
      @(negedge CLK);
      chk("lock_early", LOCKED, 0);
      send(16'h0000, 1, 0);
      idle(2);
      @(negedge CLK);
      chk("lock_set", LOCKED, 1);
      chk("lock_errcnt", ERR_CNT, 0);
      chk("lock_wordcnt", WORD_CNT, 0);

      // Counting with interleaved invalid cycles
      send(16'h0101, 1, 0);
      send(16'hABCD, 0, 0);
      send(16'hFFFF, 1, 0);
      send(16'hFFFF, 0, 0);
      send(16'h0000, 1, 0);
      idle(2);
      @(negedge CLK);
      chk("cnt_errcnt", ERR_CNT, 18);
      chk("cnt_wordcnt", WORD_CNT, 3);
      chk("cnt_locked", LOCKED, 1);

      // Third errored word in the window drops sync
      send(16'h0001, 1, 0);
      idle(1);
      @(posedge CLK);
      @(negedge CLK);
      chk("los_pulse", LOS_PULSE, 1);
      chk("los_locked", LOCKED, 0);
      chk("los_losscnt", SYNC_LOSS_CNT, 1);
      chk("los_errcnt", ERR_CNT, 19);
      chk("los_wordcnt", WORD_CNT, 4);
      @(negedge CLK);
      chk("los_pulse_end", LOS_PULSE, 0);

      // Two errors, window boundary, two more: still locked
      repeat (4) send(16'h0000, 1, 0);
      repeat (2) send(16'h8000, 1, 0);
      repeat (6) send(16'h0000, 1, 0);
      repeat (2) send(16'h8000, 1, 0);
      idle(2);
      @(negedge CLK);
      chk("win_locked", LOCKED, 1);
      chk("win_losscnt", SYNC_LOSS_CNT, 1);
      chk("win_errcnt", ERR_CNT, 23);
      chk("win_wordcnt", WORD_CNT, 14);

      // Saturation of the 8-bit error counter across repeated lock cycles
      send(16'hFFFF, 1, 0);
      repeat (6) begin
         repeat (4) send(16'h0000, 1, 0);
         repeat (3) send(16'hFFFF, 1, 0);
      end
      idle(2);
      @(negedge CLK);
      chk("sat_errcnt", ERR_CNT, 255);
      chk("sat_wordcnt", WORD_CNT, 33);
      chk("sat_losscnt", SYNC_LOSS_CNT, 8);

      // CLR coincident with a locked errored word
      repeat (4) send(16'h0000, 1, 0);
      send(16'hFFFF, 1, 0);
      send(16'h0000, 0, 1);
      send(16'h0000, 0, 0);
      @(negedge CLK);
      chk("clr_errcnt", ERR_CNT, 0);
      chk("clr_wordcnt", WORD_CNT, 0);
      chk("clr_losscnt", SYNC_LOSS_CNT, 0);
      chk("clr_locked", LOCKED, 1);

      // Reset with a word in flight
      send(16'hFFFF, 1, 0);
      do_reset();
      @(negedge CLK);
      chk("mrst_locked", LOCKED, 0);
      chk("mrst_errcnt", ERR_CNT, 0);
      chk("mrst_wordcnt", WORD_CNT, 0);
      idle(2);
      @(negedge CLK);
      chk("mrst_errcnt2", ERR_CNT, 0);
      repeat (3) send(16'h0000, 1, 0);
      idle(2);
      @(negedge CLK);
      chk("mrst_search", LOCKED, 0);

`ifdef PRBS_MON_WIN_SNAPSHOT_EN
      do_reset();
      repeat (4) send(16'h0000, 1, 0);
      repeat (2) send(16'h0003, 1, 0);
      repeat (6) send(16'h0000, 1, 0);
      idle(1);
      @(posedge CLK);
      @(negedge CLK);
      chk("snap_done", WIN_DONE, 1);
      chk("snap_err", WIN_ERR, 4);
      @(negedge CLK);
      chk("snap_done_end", WIN_DONE, 0);
`endif

      // Randomized soak with varying error density
      for (int i = 0; i < 4000; i++) begin
         case ((i / 500) % 4)
            0: rate = 2;
            1: rate = 10;
            2: rate = 25;
            default: rate = 50;
         endcase
         e = '0;
         if ($urandom_range(0, 99) < rate) begin
            if ($urandom_range(0, 1) == 1) e = NBITS'(1 << $urandom_range(0, NBITS - 1));
            else e = NBITS'($urandom);
         end
         v = ($urandom_range(0, 99) < 80);
         c = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         else send(e, v, c);
      end
      idle(3);
      @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
